// File: rtl/speed_switch_controller_pkg.sv
// speed_switch_controller_pkg: shared KEY1 constants, speed FSM states and read helper.
package speed_switch_controller_pkg;
  localparam logic [15:0] KEY1_ADDR = 16'hFF4D;
  localparam int SWITCH_CYCLES_DEFAULT = 2050;
  localparam logic [7:0] KEY1_DMG_READ = 8'hFF;
  typedef enum logic {IDLE, SWITCH} speed_state_t;
  function automatic logic [7:0] key1_read(input logic cgb_soft, input logic double_speed, input logic prepare);
    return cgb_soft ? {double_speed, 6'b111111, prepare} : KEY1_DMG_READ;
  endfunction
endpackage

// File: rtl/speed_switch_controller_if.sv
// speed_switch_controller_if: CPU-side KEY1 access, STOP handshake and speed status.
interface speed_switch_controller_if;
  logic cpu_en;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic write;
  logic cgb_soft;
  logic stop_req;
  logic stop_taken;
  logic cpu_stall;
  logic double_speed;
  logic speed_switched;
  modport master (
    output cpu_en, wdata, write, cgb_soft, stop_req,
    input rdata, stop_taken, cpu_stall, double_speed, speed_switched
  );
  modport slave (
    input cpu_en, wdata, write, cgb_soft, stop_req,
    output rdata, stop_taken, cpu_stall, double_speed, speed_switched
  );
endinterface

// File: rtl/speed_switch_controller.sv
// speed_switch_controller: KEY1 (FF4D) prepare/speed register and the STOP-driven speed switch stall.
module speed_switch_controller
  import speed_switch_controller_pkg::*;
#(
  parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEFAULT,
  parameter int CNT_W = 12
) (
  input logic clk,
  input logic reset,
  speed_switch_controller_if.slave bus
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SWITCH_CYCLES - 1);
  speed_state_t state;
  logic prepare;
  logic double_speed;
  logic cpu_stall;
  logic speed_switched;
  logic [CNT_W-1:0] counter;
  logic idle;
  logic take;
  assign idle = state == IDLE;
  // stop_req is judged against the prepare value held before any same-tick write
  assign take = bus.stop_req & prepare & bus.cgb_soft & idle;
  always_comb begin
    bus.rdata = key1_read(bus.cgb_soft, double_speed, prepare);
    bus.stop_taken = take;
    bus.cpu_stall = cpu_stall;
    bus.double_speed = double_speed;
    bus.speed_switched = speed_switched;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prepare <= 1'b0;
      double_speed <= 1'b0;
      cpu_stall <= 1'b0;
      speed_switched <= 1'b0;
      counter <= '0;
    end else if (bus.cpu_en) begin
      speed_switched <= 1'b0;
      if (idle) begin
        if (bus.write && bus.cgb_soft) prepare <= bus.wdata[0];
        if (take) begin
          state <= SWITCH;
          counter <= LOAD;
          cpu_stall <= 1'b1;
        end
      end else if (counter != '0) begin
        counter <= counter - 1'b1;
      end else begin
        state <= IDLE;
        double_speed <= ~double_speed;
        prepare <= 1'b0;
        speed_switched <= 1'b1;
        cpu_stall <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_speed_switch_controller.sv
// tb_speed_switch_controller: directed and random KEY1/speed-switch checks against a tick-count model.
module tb_speed_switch_controller;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset;
  speed_switch_controller_if bus ();
  speed_switch_controller #(.SWITCH_CYCLES(N), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic m_prep, m_ds, m_busy, m_pulse;
  int m_tick, m_end;
  int stall_clks, pulses;
  logic last_st;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_rdata(input logic cgb);
    return cgb ? 8'(8'h7E + 128 * int'(m_ds) + int'(m_prep)) : 8'hFF;
  endfunction
  // Model: a switch started on cpu_en tick t finishes on tick t+N
  task automatic step(input logic rst, input logic en, input logic w, input logic [7:0] wd,
                      input logic sr, input logic cgb);
    logic start;
    @(negedge clk);
    reset = rst;
    bus.cpu_en = en;
    bus.write = w;
    bus.wdata = wd;
    bus.stop_req = sr;
    bus.cgb_soft = cgb;
    #1;
    chk("rdata", bus.rdata, exp_rdata(cgb));
    chk("stop_taken", 8'(bus.stop_taken), 8'(sr & m_prep & cgb & ~m_busy));
    chk("cpu_stall", 8'(bus.cpu_stall), 8'(m_busy));
    chk("double_speed", 8'(bus.double_speed), 8'(m_ds));
    chk("speed_switched", 8'(bus.speed_switched), 8'(m_pulse));
    last_st = bus.stop_taken;
    stall_clks += int'(bus.cpu_stall);
    if (en && bus.speed_switched) pulses++;
    @(posedge clk);
    if (rst) begin
      m_prep = 0; m_ds = 0; m_busy = 0; m_pulse = 0;
    end else if (en) begin
      m_tick++;
      m_pulse = 0;
      if (m_busy) begin
        if (m_tick == m_end) begin
          m_ds = ~m_ds; m_prep = 0; m_busy = 0; m_pulse = 1;
        end
      end else begin
        start = sr & m_prep & cgb;
        if (w && cgb) m_prep = wd[0];
        if (start) begin
          m_busy = 1;
          m_end = m_tick + N;
        end
      end
    end
  endtask
  initial begin
    reset = 1; bus.cpu_en = 1; bus.write = 0; bus.wdata = 0; bus.stop_req = 0; bus.cgb_soft = 1;
    repeat (2) @(posedge clk);
    m_prep = 0; m_ds = 0; m_busy = 0; m_pulse = 0; m_tick = 0; m_end = 0;
    stall_clks = 0; pulses = 0;
    step(0, 1, 0, 8'h00, 0, 1);
    #1 chk("reset_rdata_cgb", bus.rdata, 8'h7E);
    chk("reset_ds", 8'(bus.double_speed), 8'h00);
    chk("reset_stall", 8'(bus.cpu_stall), 8'h00);
    step(0, 1, 0, 8'h00, 0, 0);
    #1 chk("rdata_dmg", bus.rdata, 8'hFF);
    step(0, 1, 1, 8'hFF, 0, 1);
    #1 chk("write_ff", bus.rdata, 8'h7F);
    step(0, 1, 1, 8'h00, 0, 1);
    #1 chk("write_00", bus.rdata, 8'h7E);
    step(0, 1, 1, 8'h01, 0, 0);
    step(0, 1, 0, 8'h00, 0, 1);
    #1 chk("dmg_write_ignored", bus.rdata, 8'h7E);
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 1, 8'h01, 0, 1);
      stall_clks = 0; pulses = 0;
      step(0, 1, 0, 8'h00, 1, 1);
      chk("switch_stop_taken", 8'(last_st), 8'h01);
      repeat (8) step(0, 1, 0, 8'h00, 0, 1);
      chk("switch_stall_len", 8'(stall_clks), 8'(N));
      chk("switch_pulses", 8'(pulses), 8'h01);
      #1 chk("switch_rdata", bus.rdata, r == 0 ? 8'hFE : 8'h7E);
    end
    step(0, 1, 1, 8'h01, 0, 1);
    stall_clks = 0;
    step(0, 1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 30; i++) begin
      step(0, i % 3 == 2, i == 5, 8'h00, 0, 1);
      if (i == 6) chk("write_in_switch", bus.rdata, 8'h7F);
    end
    chk("slow_stall_len", 8'(stall_clks), 8'(3 * N));
    #1 chk("slow_rdata", bus.rdata, 8'hFE);
    stall_clks = 0;
    step(0, 1, 0, 8'h00, 1, 1);
    chk("noprep_stop_taken", 8'(last_st), 8'h00);
    repeat (4) step(0, 1, 0, 8'h00, 0, 1);
    chk("noprep_stall", 8'(stall_clks), 8'h00);
    chk("noprep_ds", 8'(bus.double_speed), 8'h01);
    step(0, 1, 1, 8'h01, 0, 1);
    step(0, 1, 0, 8'h00, 1, 1);
    pulses = 0;
    step(0, 1, 0, 8'h00, 0, 1);
    step(1, 1, 0, 8'h00, 0, 1);
    stall_clks = 0;
    repeat (6) step(0, 1, 0, 8'h00, 0, 1);
    chk("abort_pulses", 8'(pulses), 8'h00);
    chk("abort_stall", 8'(stall_clks), 8'h00);
    #1 chk("abort_rdata", bus.rdata, 8'h7E);
    chk("abort_ds", 8'(bus.double_speed), 8'h00);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
           8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 9) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
